// File: rtl/uart_cmd_slave_pkg.sv
// Shared constants for the UART command slave: frame format, command-byte fields, FSM encoding.
package uart_cmd_slave_pkg;

  localparam int unsigned DataBits   = 8;
  localparam bit          ParityOdd  = 1'b1;
  localparam int unsigned CmdRwBit   = 7;
  localparam int unsigned CmdAddrMsb = 6;
  localparam int unsigned CmdAddrLsb = 0;
  localparam int unsigned AddrW      = CmdAddrMsb - CmdAddrLsb + 1;

  typedef enum logic [3:0] {
    StIdle,
    StWaitData,
    StRdReq,
    StRdCap,
    StTurn,
    StTxStart,
    StTxData,
    StTxPar,
    StTxStop
  } state_e;

  // Parity bit that makes the total count of ones (data + parity) match the frame parity.
  function automatic logic parity_bit(input logic [DataBits-1:0] d);
    return ParityOdd ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_cmd_slave_byte_rx.sv
// UART byte receiver: 2-FF synchronizer, falling-edge start detect, mid-bit sampling.
module uart_byte_rx
  import uart_cmd_slave_pkg::*;
#(
  parameter int unsigned BR = 434
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                rx_i,
  output logic [DataBits-1:0] byte_o,
  output logic                byte_valid_o,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic                active_o
);

  localparam int unsigned CntW = (BR > 1) ? $clog2(BR) : 1;
  localparam logic [CntW-1:0] CntMid  = CntW'(BR / 2);
  localparam logic [CntW-1:0] CntLast = CntW'(BR - 1);
  localparam logic [3:0] BitLastData = 4'(DataBits);
  localparam logic [3:0] BitPar      = 4'(DataBits + 1);

  logic [1:0]          sync_q;
  logic                prev_q;
  logic                active_q, active_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic [DataBits-1:0] byte_q, byte_d;
  logic                valid_q, valid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                rx_s, fall;

  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    if (!en_i) begin
      active_d = 1'b0;
      cnt_d    = '0;
      bit_d    = '0;
    end else if (!active_q) begin
      if (fall) begin
        active_d = 1'b1;
        cnt_d    = '0;
        bit_d    = '0;
      end
    end else begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
      if (cnt_q == CntLast) bit_d = bit_q + 4'd1;
      if (cnt_q == CntMid) begin
        if (bit_q == 4'd0) begin
          // Start bit high at mid-bit: treat as a glitch and go back to idle.
          if (rx_s) begin
            active_d = 1'b0;
            cnt_d    = '0;
          end
        end else if (bit_q <= BitLastData) begin
          shift_d = {rx_s, shift_q[DataBits-1:1]};
        end else if (bit_q == BitPar) begin
          par_d = rx_s;
        end else begin
          // Mid-stop: finish now so the next start edge is caught during the stop tail.
          active_d = 1'b0;
          cnt_d    = '0;
          bit_d    = '0;
          byte_d   = shift_q;
          perr_d   = (parity_bit(shift_q) != par_q);
          ferr_d   = ~rx_s;
          valid_d  = ~perr_d & ~ferr_d;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx_i};
      prev_q   <= rx_s;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign active_o     = active_q;

endmodule

// File: rtl/uart_cmd_slave.sv
// UART command slave: decodes {rw, addr} commands into register-bank strobes and replies to reads.
module uart_cmd_slave
  import uart_cmd_slave_pkg::*;
#(
  parameter int unsigned BR           = 434,
  parameter int unsigned TURN_DLY     = 100,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_i,
  output logic                tx_o,
  output logic                reg_wr_en_o,
  output logic                reg_rd_en_o,
  output logic [AddrW-1:0]    reg_addr_o,
  output logic [DataBits-1:0] reg_wdata_o,
  input  logic [DataBits-1:0] reg_rdata_i,
  output logic                err_parity_o,
  output logic                err_frame_o,
  output logic                busy_o
);

  localparam int unsigned BaudW      = (BR > 1) ? $clog2(BR) : 1;
  localparam int unsigned TimeoutCyc = TIMEOUT_BITS * BR;
  localparam int unsigned WaitMax    = (TimeoutCyc > TURN_DLY) ? TimeoutCyc : TURN_DLY;
  localparam int unsigned WaitW      = $clog2(WaitMax + 1);
  localparam logic [BaudW-1:0] BaudLast    = BaudW'(BR - 1);
  localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TimeoutCyc - 1);
  localparam logic [WaitW-1:0] TurnLast    = WaitW'(TURN_DLY - 1);
  localparam logic [3:0]       BitLast     = 4'(DataBits - 1);

  state_e              state_q, state_d;
  logic [BaudW-1:0]    baud_cnt_q;
  logic [3:0]          bit_cnt_q;
  logic [WaitW-1:0]    wait_cnt_q;
  logic [AddrW-1:0]    addr_q;
  logic [DataBits-1:0] wdata_q;
  logic [DataBits-1:0] rdata_q;
  logic                wr_en_q;

  logic                rx_en;
  logic [DataBits-1:0] rx_byte;
  logic                rx_valid, rx_perr, rx_ferr, rx_active;
  logic                baud_last, tx_phase, timeout;

  uart_byte_rx #(
    .BR (BR)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (rx_en),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .parity_err_o (rx_perr),
    .frame_err_o  (rx_ferr),
    .active_o     (rx_active)
  );

  assign baud_last = (baud_cnt_q == BaudLast);
  assign tx_phase  = (state_q == StTxStart) || (state_q == StTxData) ||
                     (state_q == StTxPar) || (state_q == StTxStop);
  assign timeout   = (state_q == StWaitData) && !rx_active && (wait_cnt_q == TimeoutLast);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (rx_valid) state_d = rx_byte[CmdRwBit] ? StWaitData : StRdReq;
      StWaitData: if (rx_valid || rx_perr || rx_ferr || timeout) state_d = StIdle;
      StRdReq:    state_d = StRdCap;
      StRdCap:    state_d = StTurn;
      StTurn:     if (wait_cnt_q == TurnLast) state_d = StTxStart;
      StTxStart:  if (baud_last) state_d = StTxData;
      StTxData:   if (baud_last && bit_cnt_q == BitLast) state_d = StTxPar;
      StTxPar:    if (baud_last) state_d = StTxStop;
      StTxStop:   if (baud_last) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_o        = 1'b1;
    reg_rd_en_o = 1'b0;
    busy_o      = (state_q != StIdle);
    rx_en       = (state_q == StIdle) || (state_q == StWaitData);
    unique case (state_q)
      StRdReq:   reg_rd_en_o = 1'b1;
      StTxStart: tx_o = 1'b0;
      StTxData:  tx_o = rdata_q[bit_cnt_q[2:0]];
      StTxPar:   tx_o = parity_bit(rdata_q);
      default:   ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wr_en_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (tx_phase) baud_cnt_q <= baud_last ? '0 : baud_cnt_q + BaudW'(1);
      else          baud_cnt_q <= '0;
      if (state_q != StTxData)  bit_cnt_q <= '0;
      else if (baud_last)       bit_cnt_q <= bit_cnt_q + 4'd1;
      // The data-byte timeout only advances while no byte is being received.
      if ((state_q == StWaitData && !rx_active) || state_q == StTurn) begin
        wait_cnt_q <= wait_cnt_q + WaitW'(1);
      end else if (state_q != StWaitData) begin
        wait_cnt_q <= '0;
      end
      if (state_q == StIdle && rx_valid) addr_q <= rx_byte[CmdAddrMsb:CmdAddrLsb];
      if (state_q == StWaitData && rx_valid) begin
        wdata_q <= rx_byte;
        wr_en_q <= 1'b1;
      end
      if (state_q == StRdCap) rdata_q <= reg_rdata_i;
    end
  end

  assign reg_wr_en_o  = wr_en_q;
  assign reg_addr_o   = addr_q;
  assign reg_wdata_o  = wdata_q;
  assign err_parity_o = rx_perr;
  assign err_frame_o  = rx_ferr;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Self-checking bench for uart_cmd_slave: directed and randomized UART transactions vs a frame model.
module tb_uart_cmd_slave;

  localparam int unsigned BR           = 434;
  localparam int unsigned TURN_DLY     = 100;
  localparam int unsigned TIMEOUT_BITS = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       tx, reg_wr_en, reg_rd_en, err_parity, err_frame, busy;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;

  // Observations collected by the monitor.
  int         wr_cnt = 0, rd_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  logic [6:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  time        rd_time = 0, perr_time = 0, ferr_time = 0;
  bit         busy_seen = 1'b0;

  // Model expectations.
  int exp_wr = 0, exp_rd = 0, exp_perr = 0, exp_ferr = 0;

  typedef struct {
    logic [10:0] first;
    logic [10:0] mid;
    logic [10:0] last;
    time         t;
  } frame_t;
  frame_t      txq[$];
  bit          mon_on = 1'b0;
  int          mon_c = 0, mon_k = 0;
  logic [10:0] mf = '0, mm = '0, ml = '0;
  time         mon_t = 0;

  always #5 clk = ~clk;

  uart_cmd_slave #(
    .BR           (BR),
    .TURN_DLY     (TURN_DLY),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .tx_o         (tx),
    .reg_wr_en_o  (reg_wr_en),
    .reg_rd_en_o  (reg_rd_en),
    .reg_addr_o   (reg_addr),
    .reg_wdata_o  (reg_wdata),
    .reg_rdata_i  (reg_rdata),
    .err_parity_o (err_parity),
    .err_frame_o  (err_frame),
    .busy_o       (busy)
  );

  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_rd_en === 1'b1) begin rd_cnt++; rd_addr = reg_addr; rd_time = $time; end
    if (err_parity === 1'b1) begin perr_cnt++; perr_time = $time; end
    if (err_frame === 1'b1) begin ferr_cnt++; ferr_time = $time; end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  // UART receiver on tx: samples first, middle and last cycle of each of the 11 bit slots.
  always @(negedge clk) begin
    if (rst) begin
      mon_on = 1'b0;
    end else begin
      if (!mon_on && tx === 1'b0) begin
        mon_on = 1'b1; mon_c = 0; mon_k = 0; mon_t = $time;
      end
      if (mon_on) begin
        if (mon_c == 0) mf[mon_k] = tx;
        if (mon_c == int'(BR / 2)) mm[mon_k] = tx;
        if (mon_c == int'(BR - 1)) ml[mon_k] = tx;
        mon_c++;
        if (mon_c == int'(BR)) begin
          mon_c = 0;
          mon_k++;
          if (mon_k == 11) begin
            mon_on = 1'b0;
            txq.push_back('{first: mf, mid: mm, last: ml, t: mon_t});
          end
        end
      end
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    return {1'b1, odd_par(d), d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip_par, input bit stop_bit);
    logic [10:0] f;
    f = {stop_bit, odd_par(b) ^ flip_par, b, 1'b0};
    for (int k = 0; k < 11; k++) begin
      rx = f[k];
      repeat (BR) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr_cnt"}, wr_cnt, exp_wr);
    check({tag, "_rd_cnt"}, rd_cnt, exp_rd);
    check({tag, "_perr_cnt"}, perr_cnt, exp_perr);
    check({tag, "_ferr_cnt"}, ferr_cnt, exp_ferr);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input string tag);
    busy_seen = 1'b0;
    send_byte({1'b1, a}, 1'b0, 1'b1);
    send_byte(d, 1'b0, 1'b1);
    exp_wr++;
    check_counts(tag);
    check({tag, "_addr"}, wr_addr, a);
    check({tag, "_wdata"}, wr_data, d);
    check({tag, "_busy_seen"}, busy_seen, 1);
    check({tag, "_no_tx"}, txq.size(), 0);
  endtask

  task automatic wait_reply(input logic [7:0] d, input string tag);
    frame_t fr;
    int     w = 0;
    while (txq.size() == 0 && w < int'(20 * BR)) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_reply_seen"}, txq.size() > 0, 1);
    if (txq.size() > 0) begin
      fr = txq.pop_front();
      check({tag, "_mid_bits"}, fr.mid, frame_of(d));
      check({tag, "_first_bits"}, fr.first, frame_of(d));
      check({tag, "_last_bits"}, fr.last, frame_of(d));
      check({tag, "_turn_gap"}, ((fr.t - rd_time) / 10 >= TURN_DLY) &&
                                ((fr.t - rd_time) / 10 <= TURN_DLY + 3), 1);
    end
    repeat (2) @(negedge clk);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    logic [6:0] ra;
    logic [7:0] rd, rb;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {tx, reg_wr_en, reg_rd_en, err_parity, err_frame, busy}, 6'b100000);
    check("reset_addr", reg_addr, 0);
    check("reset_wdata", reg_wdata, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed write 0x85 / 0x3C, then a read sent straight after it.
    do_write(7'h05, 8'h3C, "wr_dir");
    reg_rdata = 8'hA7;
    busy_seen = 1'b0;
    send_byte(8'h05, 1'b0, 1'b1);
    exp_rd++;
    check_counts("rd_dir");
    check("rd_dir_addr", rd_addr, 7'h05);
    check("rd_dir_busy_seen", busy_seen, 1);
    // A write command on rx during the reply must be ignored.
    send_byte(8'h85, 1'b0, 1'b1);
    wait_reply(8'hA7, "rd_dir");
    check_counts("rd_dir_ignored");

    // Parity error on a command byte.
    busy_seen = 1'b0;
    send_byte(8'h85, 1'b1, 1'b1);
    exp_perr++;
    repeat (4) @(negedge clk);
    check_counts("perr");
    check("perr_busy_seen", busy_seen, 0);

    // Bad parity and low stop together: both pulses in the same cycle.
    rb = 8'($urandom);
    busy_seen = 1'b0;
    send_byte(rb, 1'b1, 1'b0);
    exp_perr++;
    exp_ferr++;
    repeat (4) @(negedge clk);
    check_counts("pferr");
    check("pferr_same_cycle", perr_time == ferr_time, 1);
    check("pferr_busy_seen", busy_seen, 0);

    // Short low glitch on rx.
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (BR) @(negedge clk);
    check_counts("glitch");
    check("glitch_busy_seen", busy_seen, 0);

    // Write command with no data byte times out.
    busy_seen = 1'b0;
    send_byte(8'h85, 1'b0, 1'b1);
    check("tmo_busy_seen", busy_seen, 1);
    repeat (TIMEOUT_BITS * BR - BR) @(negedge clk);
    check("tmo_busy_before", busy, 1);
    repeat (BR + 20) @(negedge clk);
    check("tmo_busy_after", busy, 0);
    check_counts("tmo");
    ra = 7'($urandom);
    rd = 8'($urandom);
    do_write(ra, rd, "wr_rand");

    // Reset in the middle of a reply's data bits.
    reg_rdata = 8'($urandom);
    send_byte(8'h05, 1'b0, 1'b1);
    exp_rd++;
    repeat (2 * BR) @(negedge clk);
    check("rst_mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy_low", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (BR) @(negedge clk);
    check("rst_mid_no_frame", txq.size(), 0);
    check_counts("rst_mid");
    rd = 8'($urandom);
    reg_rdata = rd;
    send_byte(8'h05, 1'b0, 1'b1);
    exp_rd++;
    check("rd_post_addr", rd_addr, 7'h05);
    wait_reply(rd, "rd_post");
    check_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
